// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver with input synchronizer, valid/ready output and error pulses.
// Ports:
//   clk         - system clock, all logic on rising edge
//   rst_n       - synchronous active-low reset
//   clk_div     - clock cycles per bit (values below 4 behave as 4)
//   rx_i        - asynchronous serial input, idle high, LSB first
//   rx_data     - last received byte
//   rx_valid    - rx_data holds an unread byte
//   rx_ready    - consumer accepts rx_data when rx_valid && rx_ready
//   busy        - receiver FSM is not idle
//   frame_err   - one-cycle pulse when the stop bit samples low
//   overrun_err - one-cycle pulse when a completed byte is dropped
module uart_rx_core #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] clk_div,
    input  logic        rx_i,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun_err
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic        rxs, prev_q, tick, done;
    logic [15:0] cnt_q, cnt_d, div_q, div_d, eff_div;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d, data_q, data_d;
    logic        valid_q, valid_d, ferr_q, ferr_d, oerr_q, oerr_d;
    assign rxs     = sync_q[SYNC_STAGES-1];
    assign tick    = cnt_q == 16'd0;
    assign eff_div = clk_div < 16'd4 ? 16'd4 : clk_div;
    // a good stop bit completes the frame; the byte is already fully shifted in
    assign done    = state_q == STOP && tick && rxs;
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? 16'd0 : cnt_q - 16'd1;
        div_d   = div_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: if (prev_q && !rxs) begin
                div_d   = eff_div;
                cnt_d   = (eff_div >> 1) - 16'd1;
                state_d = START;
            end
            START: if (tick) begin
                state_d = rxs ? IDLE : DATA;
                cnt_d   = div_q - 16'd1;
                idx_d   = 3'd0;
            end
            DATA: if (tick) begin
                shift_d = {rxs, shift_q[7:1]};
                idx_d   = idx_q + 3'd1;
                cnt_d   = div_q - 16'd1;
                state_d = idx_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (tick) begin
                ferr_d  = !rxs;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a handshake on the completion cycle frees the slot for the new byte
        data_d  = done && (!valid_q || rx_ready) ? shift_q : data_q;
        valid_d = done || (valid_q && !rx_ready);
        oerr_d  = done && valid_q && !rx_ready;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q  <= rxs;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end
    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign busy        = state_q != IDLE;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: scoreboard bench for uart_rx_core with directed frames.
`timescale 1ns/100ps
module tb_uart_rx_core;
    localparam int SYNC = 2;
    logic        clk = 1'b0, rst_n = 1'b0, rx_i = 1'b1, rx_ready = 1'b0;
    logic [15:0] clk_div = 16'd16;
    logic [7:0]  rx_data;
    logic        rx_valid, busy, frame_err, overrun_err;
    realtime     half = 5.0;
    int          total = 0, passed = 0, valid_cycles = 0;
    logic        fe_prev = 1'b0, oe_prev = 1'b0;
    logic [9:0]  exp_q[$];

    uart_rx_core #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .rx_i(rx_i),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .frame_err(frame_err), .overrun_err(overrun_err)
    );

    always #(half) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // event kinds: 0 = byte handed over, 1 = frame_err, 2 = overrun_err
    task automatic pop_check(input logic [1:0] kind, input logic [7:0] data);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_event: got kind %0d data %0h expected no event", kind, data);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", {30'd0, kind}, {30'd0, e[9:8]});
            if (kind == 2'd0) chk("rx_data", {24'd0, data}, {24'd0, e[7:0]});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_cycles++;
            if (frame_err) begin
                chk("frame_err_width", {31'd0, fe_prev}, 0);
                pop_check(2'd1, 8'h00);
            end
            if (overrun_err) begin
                chk("overrun_err_width", {31'd0, oe_prev}, 0);
                pop_check(2'd2, 8'h00);
            end
            if (rx_valid && rx_ready) pop_check(2'd0, rx_data);
        end
        fe_prev = frame_err;
        oe_prev = overrun_err;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int div);
        rx_i = v;
        repeat (div) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int div);
        @(posedge clk);
        #1;
        drive_bit(1'b0, div);
        for (int i = 0; i < 8; i++) drive_bit(b[i], div);
        drive_bit(stop, div);
        rx_i = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " rx_data"}, {24'd0, rx_data}, 0);
        chk({tag, " rx_valid"}, {31'd0, rx_valid}, 0);
        chk({tag, " busy"}, {31'd0, busy}, 0);
        chk({tag, " frame_err"}, {31'd0, frame_err}, 0);
        chk({tag, " overrun_err"}, {31'd0, overrun_err}, 0);
    endtask

    initial begin
        int vc;
        logic seen, held;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_cycles(5);

        // basic byte, consumer always ready
        rx_ready = 1'b1;
        exp_q.push_back({2'd0, 8'h3D});
        vc = valid_cycles;
        send_frame(8'h3D, 1'b1, 16);
        wait_cycles(8);
        chk("t1 valid_cycles", valid_cycles - vc, 1);
        chk("t1 drained", exp_q.size(), 0);
        chk("t1 busy", {31'd0, busy}, 0);

        // real baud divisor at 40 MHz
        half = 12.5;
        wait_cycles(2);
        clk_div = 16'd4167;
        exp_q.push_back({2'd0, 8'h3D});
        vc = valid_cycles;
        send_frame(8'h3D, 1'b1, 4167);
        wait_cycles(8);
        chk("t2 valid_cycles", valid_cycles - vc, 1);
        chk("t2 drained", exp_q.size(), 0);
        half = 5.0;
        clk_div = 16'd16;
        wait_cycles(4);

        // overrun: second byte dropped, first kept
        rx_ready = 1'b0;
        exp_q.push_back({2'd2, 8'h00});
        exp_q.push_back({2'd0, 8'h0F});
        send_frame(8'h0F, 1'b1, 16);
        send_frame(8'h3D, 1'b1, 16);
        wait_cycles(8);
        chk("t3 rx_valid", {31'd0, rx_valid}, 1);
        chk("t3 rx_data kept", {24'd0, rx_data}, 32'h0F);
        chk("t3 pending", exp_q.size(), 1);
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        wait_cycles(2);
        chk("t3 drained", exp_q.size(), 0);
        chk("t3 rx_valid cleared", {31'd0, rx_valid}, 0);

        // bad stop bit
        rx_ready = 1'b1;
        exp_q.push_back({2'd1, 8'h00});
        vc = valid_cycles;
        send_frame(8'h55, 1'b0, 16);
        wait_cycles(8);
        chk("t4 valid_cycles", valid_cycles - vc, 0);
        chk("t4 busy", {31'd0, busy}, 0);
        chk("t4 drained", exp_q.size(), 0);

        // 4-cycle glitch
        vc = valid_cycles;
        seen = 1'b0;
        @(posedge clk);
        #1 rx_i = 1'b0;
        wait_cycles(4);
        rx_i = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        wait_cycles(10);
        chk("t5 busy seen", {31'd0, seen}, 1);
        chk("t5 busy idle", {31'd0, busy}, 0);
        chk("t5 valid_cycles", valid_cycles - vc, 0);
        chk("t5 drained", exp_q.size(), 0);

        // reset during bit 3, then a clean frame
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 16);
        rx_i = 1'b0;
        wait_cycles(5);
        chk("t6 busy before reset", {31'd0, busy}, 1);
        rst_n = 1'b0;
        wait_cycles(2);
        rx_i = 1'b1;
        @(negedge clk);
        check_reset_outputs("t6 in reset");
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(10);
        chk("t6 busy after release", {31'd0, busy}, 0);
        exp_q.push_back({2'd0, 8'hA5});
        send_frame(8'hA5, 1'b1, 16);
        wait_cycles(8);
        chk("t6 drained", exp_q.size(), 0);
        chk("t6 rx_valid", {31'd0, rx_valid}, 0);

        // handshake lands exactly on the completion cycle of the second byte
        rx_ready = 1'b0;
        exp_q.push_back({2'd0, 8'h0F});
        exp_q.push_back({2'd0, 8'h3D});
        send_frame(8'h0F, 1'b1, 16);
        held = 1'b1;
        fork
            send_frame(8'h3D, 1'b1, 16);
            begin
                repeat (SYNC + 1 + 8 + 9 * 16) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
            repeat (SYNC + 20 + 10 * 16) begin
                @(negedge clk);
                if (!rx_valid) held = 1'b0;
            end
        join
        chk("t7 valid held", {31'd0, held}, 1);
        chk("t7 rx_data new", {24'd0, rx_data}, 32'h3D);
        chk("t7 pending", exp_q.size(), 1);
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        wait_cycles(2);
        chk("t7 drained", exp_q.size(), 0);
        chk("t7 rx_valid cleared", {31'd0, rx_valid}, 0);

        // divisor below minimum runs at 4 cycles per bit
        clk_div = 16'd2;
        rx_ready = 1'b1;
        exp_q.push_back({2'd0, 8'h96});
        vc = valid_cycles;
        send_frame(8'h96, 1'b1, 4);
        wait_cycles(8);
        chk("t8 valid_cycles", valid_cycles - vc, 1);
        chk("t8 drained", exp_q.size(), 0);

        chk("final drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
